fetch_stage: RTL and testbench

Instruction-fetch stage of the PD5 pipeline, directly upstream of decode. It owns the fetch PC and drives a synchronous instruction memory with one-cycle read latency. It presents a registered IF/ID bundle (valid, PC, instruction) that decode and the register-read probes consume. It honours stall, redirect and halt requests from later stages.

---
 rtl/pd_pkg.sv | 22 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared PD5 pipeline definitions: fetch FSM states, IF/ID payload and constants.
package pd_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0100_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
    logic            misaligned;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage control, instruction-memory and IF/ID signals as one bundle.
interface fetch_stage_if;
  import pd_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_insn;
  logic            id_misaligned;
  logic [XLEN-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, halt, imem_rdata,
    output imem_addr, id_valid, id_pc, id_insn, id_misaligned, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, halt, imem_rdata,
    input  imem_addr, id_valid, id_pc, id_insn, id_misaligned, fetch_count
  );

endinterface

// File: rtl/fetch_stage.sv
// PD5 instruction fetch: owns the fetch PC, drives a 1-cycle imem and
// registers the IF/ID bundle under halt > redirect > stall > advance priority.
module fetch_stage
  import pd_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clock,
  input  logic          reset,
  fetch_stage_if.master bus
);

  localparam int unsigned PC_STEP = 4;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  logic            f_mis_q, f_mis_d;
  if_id_t          id_q, id_d;
  logic [XLEN-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      f_mis_q   <= 1'b0;
      id_q      <= '{valid: 1'b0, pc: '0, insn: NOP_INSN, misaligned: 1'b0};
      cnt_q     <= '0;
    end else begin
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      f_mis_q   <= f_mis_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state, next PC and IF/ID update
  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    f_mis_d   = f_mis_q;
    id_d      = id_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d   = RUN;
        f_pc_d    = RESET_PC;
        f_valid_d = 1'b1;
        f_mis_d   = 1'b0;
      end
      RUN: begin
        if (bus.halt) begin
          state_d    = HALTED;
          f_valid_d  = 1'b0;
          id_d.valid = 1'b0;
          id_d.insn  = NOP_INSN;
        end else if (bus.redirect_valid) begin
          // Wrong-path kill: the instruction currently in F is dropped.
          f_pc_d     = bus.redirect_pc;
          f_valid_d  = 1'b1;
          f_mis_d    = |bus.redirect_pc[1:0];
          id_d.valid = 1'b0;
          id_d.insn  = NOP_INSN;
        end else if (!bus.stall) begin
          f_pc_d          = f_pc_q + XLEN'(PC_STEP);
          id_d.valid      = f_valid_q;
          id_d.pc         = f_pc_q;
          id_d.insn       = f_valid_q ? bus.imem_rdata : NOP_INSN;
          id_d.misaligned = f_mis_q;
          if (f_valid_q) begin
            cnt_d = cnt_q + XLEN'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.imem_addr     = {f_pc_d[XLEN-1:2], 2'b00};
  assign bus.id_valid      = id_q.valid;
  assign bus.id_pc         = id_q.pc;
  assign bus.id_insn       = id_q.insn;
  assign bus.id_misaligned = id_q.misaligned;
  assign bus.fetch_count   = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scoreboard of delivered instructions
// plus directed checks of stall, redirect, misalignment, halt, reset and PC wrap.
module tb_fetch_stage;
  import pd_pkg::*;

  localparam logic [31:0] R   = 32'h0100_0000;
  localparam logic [31:0] R2  = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        mis;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  logic [31:0] last_cnt = '0;

  always #5 clk = ~clk;

  fetch_stage_if b ();
  fetch_stage_if w ();

  fetch_stage #(.RESET_PC(R))  dut      (.clock(clk), .reset(rst_n), .bus(b.master));
  fetch_stage #(.RESET_PC(R2)) dut_wrap (.clock(clk), .reset(rst_n), .bus(w.master));

  // Synchronous instruction memory: mem[a] = a ^ KEY, one-cycle latency.
  always @(posedge clk) begin
    b.imem_rdata <= b.imem_addr ^ KEY;
    w.imem_rdata <= w.imem_addr ^ KEY;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc   = pc;
    e.insn = {pc[31:2], 2'b00} ^ KEY;
    e.mis  = mis;
    q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(b.id_valid), 32'd0);
    check({tag, "_pc"}, b.id_pc, 32'd0);
    check({tag, "_insn"}, b.id_insn, NOP_INSN);
    check({tag, "_mis"}, 32'(b.id_misaligned), 32'd0);
    check({tag, "_cnt"}, b.fetch_count, 32'd0);
    check({tag, "_addr"}, b.imem_addr, R);
  endtask

  // Scoreboard: every fetch_count step is one delivery, compared against the queue.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_cnt = '0;
    end else if (b.fetch_count !== last_cnt) begin
      exp_t e;
      check("cnt_step", b.fetch_count, last_cnt + 32'd1);
      check("deliv_valid", 32'(b.id_valid), 32'd1);
      if (q.size() == 0) begin
        check("sb_underflow", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        check("sb_pc", b.id_pc, e.pc);
        check("sb_insn", b.id_insn, e.insn);
        check("sb_mis", 32'(b.id_misaligned), 32'(e.mis));
      end
      last_cnt = b.fetch_count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    b.stall = 0; b.redirect_valid = 0; b.redirect_pc = '0; b.halt = 0;
    w.stall = 0; w.redirect_valid = 0; w.redirect_pc = '0; w.halt = 0;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    check("wrap_rst_addr", w.imem_addr, R2);

    for (int i = 0; i < 4; i++) push(R + 32'(4 * i), 1'b0);
    rst_n = 1'b1;

    @(negedge clk); // edge 1
    check("e1_valid", 32'(b.id_valid), 32'd0);
    check("e1_addr", b.imem_addr, R + 32'h4);
    @(negedge clk); // edge 2
    check("e2_valid", 32'(b.id_valid), 32'd1);
    check("e2_pc", b.id_pc, 32'h0100_0000);
    check("e2_insn", b.id_insn, 32'hA4A5_0000);
    check("wrap_e2", w.id_pc, 32'hFFFF_FFF8);
    @(negedge clk); // edge 3
    check("e3_pc", b.id_pc, 32'h0100_0004);
    check("e3_cnt", b.fetch_count, 32'd2);
    check("wrap_e3", w.id_pc, 32'hFFFF_FFFC);
    @(negedge clk); // edge 4
    check("e4_pc", b.id_pc, 32'h0100_0008);
    check("wrap_e4_pc", w.id_pc, 32'h0000_0000);
    check("wrap_e4_insn", w.id_insn, KEY);

    // Stall for three cycles with id_pc = R+8
    b.stall = 1'b1;
    #1 check("stall_addr0", b.imem_addr, 32'h0100_000C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", b.id_pc, 32'h0100_0008);
      check("stall_valid", 32'(b.id_valid), 32'd1);
      check("stall_cnt", b.fetch_count, 32'd3);
      check("stall_addr", b.imem_addr, 32'h0100_000C);
    end
    b.stall = 1'b0;
    @(negedge clk);
    check("resume_pc", b.id_pc, 32'h0100_000C);
    check("resume_cnt", b.fetch_count, 32'd4);

    // Redirect with stall also high
    push(R + 32'h40, 1'b0);
    b.redirect_valid = 1'b1; b.redirect_pc = R + 32'h40; b.stall = 1'b1;
    #1 check("redir_addr", b.imem_addr, 32'h0100_0040);
    @(negedge clk);
    b.redirect_valid = 1'b0; b.stall = 1'b0;
    check("redir_kill_valid", 32'(b.id_valid), 32'd0);
    check("redir_kill_insn", b.id_insn, NOP_INSN);
    check("redir_kill_cnt", b.fetch_count, 32'd4);
    push(R + 32'h44, 1'b0);
    @(negedge clk);
    check("redir_tgt_pc", b.id_pc, 32'h0100_0040);
    check("redir_tgt_valid", 32'(b.id_valid), 32'd1);
    @(negedge clk);
    check("redir_next_pc", b.id_pc, 32'h0100_0044);

    // Misaligned redirect target
    push(R + 32'h42, 1'b1);
    push(R + 32'h46, 1'b1);
    b.redirect_valid = 1'b1; b.redirect_pc = R + 32'h42;
    #1 check("mis_addr", b.imem_addr, 32'h0100_0040);
    @(negedge clk);
    b.redirect_valid = 1'b0;
    check("mis_kill_valid", 32'(b.id_valid), 32'd0);
    #1 check("mis_next_addr", b.imem_addr, 32'h0100_0044);
    @(negedge clk);
    check("mis_pc", b.id_pc, 32'h0100_0042);
    check("mis_flag", 32'(b.id_misaligned), 32'd1);
    @(negedge clk);
    check("mis_next_pc", b.id_pc, 32'h0100_0046);
    check("mis_cnt", b.fetch_count, 32'd8);

    // Halt, then random stall/redirect activity that must not restart fetch
    b.halt = 1'b1;
    @(negedge clk);
    b.halt = 1'b0;
    check("halt_valid", 32'(b.id_valid), 32'd0);
    check("halt_insn", b.id_insn, NOP_INSN);
    for (int i = 0; i < 10; i++) begin
      b.stall          = 1'($urandom_range(0, 1));
      b.redirect_valid = 1'($urandom_range(0, 1));
      b.halt           = 1'($urandom_range(0, 1));
      b.redirect_pc    = R + 32'h100;
      @(negedge clk);
      check("halted_valid", 32'(b.id_valid), 32'd0);
      check("halted_cnt", b.fetch_count, 32'd8);
      check("halted_addr", b.imem_addr, 32'h0100_0048);
    end
    b.stall = 0; b.redirect_valid = 0; b.halt = 0;
    check("sb_drained", 32'(q.size()), 32'd0);

    // One-cycle reset pulse leaves HALTED
    rst_n = 1'b0;
    #1 check_reset_vals("pulse");
    @(negedge clk);
    push(R, 1'b0);
    push(R + 32'h4, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerun_e1_valid", 32'(b.id_valid), 32'd0);
    @(negedge clk);
    check("rerun_e2_valid", 32'(b.id_valid), 32'd1);
    check("rerun_e2_pc", b.id_pc, R);
    @(negedge clk);
    check("rerun_e3_cnt", b.fetch_count, 32'd2);
    b.halt = 1'b1;
    @(negedge clk);
    check("rerun_halt_valid", 32'(b.id_valid), 32'd0);
    check("final_sb_empty", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
